// File: rtl/sd_types_pkg.sv
// sd_types_pkg: shared SD CRC-status tokens and the CRC-status FSM state type
package sd_types_pkg;
  localparam logic [2:0] SD_CRC_STATUS_OK = 3'b010;
  localparam logic [2:0] SD_CRC_STATUS_ERR = 3'b101;
  typedef enum logic [2:0] {IDLE, GAP, TOKEN, BUSY, RELEASE} crc_status_state_t;
endpackage

// File: rtl/sd_clock_edge_detect.sv
// sd_clock_edge_detect: 2-FF synchroniser on sd_clock (in clock/reset/sd_clock) giving one-cycle rise/fall pulses (out rise/fall)
module sd_clock_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic sd_clock,
  output logic rise,
  output logic fall
);
  logic [2:0] sh;
  always_ff @(posedge clock or posedge reset)
    if (reset) sh <= '0;
    else sh <= {sh[1:0], sd_clock};
  assign rise = ~sh[2] & sh[1];
  assign fall = sh[2] & ~sh[1];
endmodule

// File: rtl/sd_write_crc_status.sv
// sd_write_crc_status: sends the SD CRC-status token and write busy on DAT0 (in block_done/crc_ok/busy_in/abort/sd_clock; out dat0_out/dat0_oe/card_busy/status_done/crc_err_count)
module sd_write_crc_status
  import sd_types_pkg::*;
#(
  parameter int GAP_CLOCKS = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sd_clock,
  input  logic                 block_done,
  input  logic                 crc_ok,
  input  logic                 busy_in,
  input  logic                 abort,
  output logic                 dat0_out,
  output logic                 dat0_oe,
  output logic                 card_busy,
  output logic                 status_done,
  output logic [ERR_CNT_W-1:0] crc_err_count
);
  localparam int FW = $clog2(GAP_CLOCKS + 3);
  crc_status_state_t state;
  logic [FW-1:0] fall_cnt;
  logic [1:0] bit_idx;
  logic [2:0] status;
  logic [3:0] token_bits;
  logic fall, rise_unused;
  sd_clock_edge_detect u_edge (
    .clock(clock),
    .reset(reset),
    .sd_clock(sd_clock),
    .rise(rise_unused),
    .fall(fall)
  );
  assign token_bits = {status, 1'b1};
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      dat0_out <= 1'b1;
      dat0_oe <= 1'b0;
      card_busy <= 1'b0;
      status_done <= 1'b0;
      crc_err_count <= '0;
      fall_cnt <= '0;
      bit_idx <= '0;
      status <= SD_CRC_STATUS_OK;
    end else begin
      status_done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        dat0_oe <= 1'b0;
        dat0_out <= 1'b1;
        card_busy <= 1'b0;
      end else
        case (state)
          IDLE:
            if (block_done) begin
              status <= crc_ok ? SD_CRC_STATUS_OK : SD_CRC_STATUS_ERR;
              card_busy <= 1'b1;
              fall_cnt <= '0;
              if (!crc_ok && !(&crc_err_count)) crc_err_count <= crc_err_count + 1'b1;
              state <= GAP;
            end
          GAP:
            if (fall) begin
              fall_cnt <= fall_cnt + 1'b1;
              if (fall_cnt == FW'(GAP_CLOCKS + 1)) begin
                dat0_oe <= 1'b1;
                dat0_out <= 1'b0;
                bit_idx <= '0;
                state <= TOKEN;
              end
            end
          TOKEN:
            if (fall) begin
              bit_idx <= bit_idx + 1'b1;
              dat0_out <= token_bits[2'd3 - bit_idx];
              if (bit_idx == 2'd3) state <= (status == SD_CRC_STATUS_OK && busy_in) ? BUSY : RELEASE;
            end
          BUSY:
            if (fall) begin
              dat0_out <= !busy_in;
              if (!busy_in) state <= RELEASE;
            end
          RELEASE:
            if (fall) begin
              dat0_oe <= 1'b0;
              dat0_out <= 1'b1;
              card_busy <= 1'b0;
              status_done <= 1'b1;
              state <= IDLE;
            end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_sd_write_crc_status.sv
// tb_sd_write_crc_status: randomized self-checking bench comparing DAT0 per sd_clock fall against a token-level model
module tb_sd_write_crc_status;
  localparam int GAP = 2;
  logic clock = 0, reset = 1, sd_clock = 1, block_done = 0, crc_ok = 0, busy_in = 0, abort = 0;
  logic dat0_out, dat0_oe, card_busy, status_done;
  logic [7:0] crc_err_count;
  int n_checks = 0, n_fail = 0, done_cnt = 0, err_model = 0, d0;
  sd_write_crc_status #(.GAP_CLOCKS(GAP), .ERR_CNT_W(8)) dut (
    .clock(clock),
    .reset(reset),
    .sd_clock(sd_clock),
    .block_done(block_done),
    .crc_ok(crc_ok),
    .busy_in(busy_in),
    .abort(abort),
    .dat0_out(dat0_out),
    .dat0_oe(dat0_oe),
    .card_busy(card_busy),
    .status_done(status_done),
    .crc_err_count(crc_err_count)
  );
  always #5 clock = ~clock;
  always @(negedge clock) if (status_done === 1'b1) done_cnt++;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic sd_cycle();
    @(negedge clock) sd_clock = 0;
    repeat (3) @(negedge clock);
    @(negedge clock) sd_clock = 1;
    repeat (3) @(negedge clock);
  endtask
  task automatic pulse_done(bit c);
    block_done = 1;
    crc_ok = c;
    @(negedge clock);
    block_done = 0;
    crc_ok = 1'($urandom);
  endtask
  task automatic run_block(bit c, int busy_len, bit extra_done, int stop_at);
    logic [4:0] tok;
    int d;
    tok = {1'b0, c ? 3'b010 : 3'b101, 1'b1};
    d = done_cnt;
    pulse_done(c);
    if (!c && err_model < 255) err_model++;
    check("card_busy_set", card_busy, 1);
    for (int k = 1; k <= GAP + 1; k++) begin
      busy_in = 1'($urandom);
      sd_cycle();
      check("gap_oe", dat0_oe, 0);
      if (extra_done && k == 1) pulse_done(!c);
    end
    for (int i = 4; i >= 0; i--) begin
      busy_in = (i == 0) ? ((busy_len > 0) || (!c && 1'($urandom))) : 1'($urandom);
      sd_cycle();
      check("tok_oe", dat0_oe, 1);
      check("tok_bit", dat0_out, tok[i]);
      check("tok_card_busy", card_busy, 1);
    end
    if (c && busy_len > 0) begin
      for (int j = 0; j < busy_len; j++) begin
        busy_in = 1;
        if (j == stop_at)
          for (int s = 0; s < 10; s++) begin
            repeat (100) @(negedge clock);
            check("frozen_oe", dat0_oe, 1);
            check("frozen_out", dat0_out, 0);
            check("frozen_card_busy", card_busy, 1);
          end
        sd_cycle();
        check("busy_out", dat0_out, 0);
        check("busy_oe", dat0_oe, 1);
      end
      busy_in = 0;
      sd_cycle();
      check("busy_end_out", dat0_out, 1);
      check("busy_end_card_busy", card_busy, 1);
    end
    busy_in = 1'($urandom);
    sd_cycle();
    check("rel_oe", dat0_oe, 0);
    check("rel_out", dat0_out, 1);
    check("rel_card_busy", card_busy, 0);
    check("rel_done_once", done_cnt, d + 1);
    check("err_count", crc_err_count, err_model);
    busy_in = 0;
  endtask
  initial begin
    repeat (3) @(negedge clock);
    check("rst_out", dat0_out, 1);
    check("rst_oe", dat0_oe, 0);
    check("rst_card_busy", card_busy, 0);
    check("rst_status_done", status_done, 0);
    check("rst_err_count", crc_err_count, 0);
    reset = 0;
    repeat (2) @(negedge clock);
    run_block(1, 0, 0, -1);
    run_block(0, 0, 0, -1);
    run_block(1, 20, 0, -1);
    for (int n = 0; n < 12; n++) run_block(1'($urandom), $urandom_range(0, 4), n % 3 == 0, -1);
    pulse_done(1);
    repeat (GAP + 3) sd_cycle();
    abort = 1;
    @(negedge clock);
    abort = 0;
    check("abort_oe", dat0_oe, 0);
    check("abort_out", dat0_out, 1);
    check("abort_card_busy", card_busy, 0);
    d0 = done_cnt;
    repeat (4) sd_cycle();
    check("abort_idle_oe", dat0_oe, 0);
    check("abort_no_done", done_cnt, d0);
    run_block(1, 0, 0, -1);
    block_done = 1;
    crc_ok = 0;
    abort = 1;
    @(negedge clock);
    block_done = 0;
    abort = 0;
    check("abort_bd_card_busy", card_busy, 0);
    check("abort_bd_err_count", crc_err_count, err_model);
    repeat (6) sd_cycle();
    check("abort_bd_oe", dat0_oe, 0);
    run_block(1, 6, 0, 3);
    pulse_done(1);
    busy_in = 1;
    repeat (GAP + 8) sd_cycle();
    check("pre_rst_oe", dat0_oe, 1);
    check("pre_rst_out", dat0_out, 0);
    #1 reset = 1;
    #1;
    check("async_rst_oe", dat0_oe, 0);
    check("async_rst_card_busy", card_busy, 0);
    check("async_rst_out", dat0_out, 1);
    check("async_rst_err", crc_err_count, 0);
    err_model = 0;
    busy_in = 0;
    @(negedge clock) reset = 0;
    repeat (2) @(negedge clock);
    run_block(1, 2, 0, -1);
    for (int n = 0; n < 258; n++) run_block(0, 0, n == 100, -1);
    check("err_saturated", crc_err_count, 255);
    run_block(1, 1, 0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
